// File: rtl/rapid_recovery_pkg.sv
// Shared types and helpers for the rapid-recovery group arbiter.
// Holds the arbiter state encoding and a width helper used for index/counter sizing.
package rapid_recovery_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_BUSY,
        ARB_COOLDOWN
    } recovery_arb_state_e;

    // Counter and index widths never drop below one bit, even for degenerate parameters.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/recovery_group_arbiter_if.sv
// Bundle of signals between the DMR groups / recovery controller and the group arbiter.
// The arbiter uses the slave modport; the controller side (or a bench) uses master.
interface recovery_group_arbiter_if #(
    parameter int NumGroups = 4
);
    localparam int IdxW = (NumGroups > 1) ? $clog2(NumGroups) : 1;

    logic [NumGroups-1:0] group_error_i;
    logic                 recovery_req_o;
    logic [IdxW-1:0]      recovery_group_o;
    logic                 recovery_ack_i;
    logic                 recovery_done_i;
    logic [NumGroups-1:0] group_clk_en_o;
    logic [NumGroups-1:0] pending_o;
    logic                 busy_o;
    logic                 fatal_o;

    modport slave (
        input  group_error_i,
        input  recovery_ack_i,
        input  recovery_done_i,
        output recovery_req_o,
        output recovery_group_o,
        output group_clk_en_o,
        output pending_o,
        output busy_o,
        output fatal_o
    );

    modport master (
        output group_error_i,
        output recovery_ack_i,
        output recovery_done_i,
        input  recovery_req_o,
        input  recovery_group_o,
        input  group_clk_en_o,
        input  pending_o,
        input  busy_o,
        input  fatal_o
    );

endinterface

// File: rtl/recovery_group_arbiter_rr_picker.sv
// Round-robin picker: first set pending bit at or after ptr_i, wrapping around.
// Purely combinational; the arbiter registers whatever it selects.
module recovery_rr_picker
    import rapid_recovery_pkg::*;
#(
    parameter  int NumGroups = 4,
    localparam int IdxW      = clog2_min1(NumGroups)
) (
    input  logic [NumGroups-1:0] pending_i,
    input  logic [IdxW-1:0]      ptr_i,
    output logic                 valid_o,
    output logic [IdxW-1:0]      idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < NumGroups; k++) begin
            if (!valid_o && pending_i[(int'(ptr_i) + k) % NumGroups]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'((int'(ptr_i) + k) % NumGroups);
            end
        end
    end

endmodule

// File: rtl/recovery_group_arbiter.sv
// Serialises per-group recovery requests onto one shared recovery controller,
// gating the clocks of all other groups while a recovery is in flight.
module recovery_group_arbiter
    import rapid_recovery_pkg::*;
#(
    parameter int NumGroups      = 4,
    parameter int TimeoutCycles  = 256,
    parameter int CooldownCycles = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    recovery_group_arbiter_if.slave  bus
);

    localparam int IdxW = clog2_min1(NumGroups);
    localparam int WdW  = clog2_min1(TimeoutCycles);
    localparam int CdW  = clog2_min1(CooldownCycles + 1);

    recovery_arb_state_e  state_q, state_d;
    logic [NumGroups-1:0] pending_q, pending_d;
    logic [NumGroups-1:0] clk_en_q, clk_en_d;
    logic [IdxW-1:0]      grp_q, grp_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WdW-1:0]       wd_q, wd_d;
    logic [CdW-1:0]       cd_q, cd_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;
    logic                 fatal_q, fatal_d;

    logic                 sel_valid;
    logic [IdxW-1:0]      sel_idx;
    logic                 active;
    logic                 handshake;
    logic [NumGroups-1:0] grp_onehot;
    logic [NumGroups-1:0] masked_err;

    recovery_rr_picker #(
        .NumGroups (NumGroups)
    ) u_picker (
        .pending_i (pending_q),
        .ptr_i     (rr_ptr_q),
        .valid_o   (sel_valid),
        .idx_o     (sel_idx)
    );

    assign active     = (state_q == ARB_REQ) || (state_q == ARB_BUSY);
    assign handshake  = (state_q == ARB_REQ) && bus.recovery_ack_i;
    assign grp_onehot = NumGroups'(1) << grp_q;

    // The group under recovery cannot re-arm its own pending bit until it leaves REQ/BUSY.
    assign masked_err = active ? (bus.group_error_i & ~grp_onehot) : bus.group_error_i;

    always_comb begin
        pending_d = pending_q | masked_err;
        if (handshake) begin
            pending_d = pending_d & ~grp_onehot;
        end
    end

    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        rr_ptr_d = rr_ptr_q;
        wd_d     = wd_q;
        cd_d     = cd_q;
        fatal_d  = fatal_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (sel_valid) begin
                    grp_d   = sel_idx;
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (bus.recovery_ack_i) begin
                    rr_ptr_d = (int'(grp_q) == NumGroups - 1) ? '0 : grp_q + 1'b1;
                    wd_d     = '0;
                    state_d  = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (bus.recovery_done_i) begin
                    cd_d    = '0;
                    state_d = (CooldownCycles == 0) ? ARB_IDLE : ARB_COOLDOWN;
                end else if (int'(wd_q) >= TimeoutCycles - 1) begin
                    // Abandon the stuck recovery but keep arbitrating; fatal stays up.
                    fatal_d = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ARB_COOLDOWN: begin
                if (int'(cd_q) >= CooldownCycles - 1) begin
                    state_d = ARB_IDLE;
                end else begin
                    cd_d = cd_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        req_d    = (state_d == ARB_REQ);
        busy_d   = (state_d != ARB_IDLE);
        clk_en_d = active ? grp_onehot : '1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            pending_q <= '0;
            clk_en_q  <= '1;
            grp_q     <= '0;
            rr_ptr_q  <= '0;
            wd_q      <= '0;
            cd_q      <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            fatal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            clk_en_q  <= clk_en_d;
            grp_q     <= grp_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_q      <= wd_d;
            cd_q      <= cd_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            fatal_q   <= fatal_d;
        end
    end

    assign bus.recovery_req_o   = req_q;
    assign bus.recovery_group_o = grp_q;
    assign bus.group_clk_en_o   = clk_en_q;
    assign bus.pending_o        = pending_q;
    assign bus.busy_o           = busy_q;
    assign bus.fatal_o          = fatal_q;

endmodule

// File: tb/tb_recovery_group_arbiter.sv
// Self-checking bench for recovery_group_arbiter: table of single-error recoveries plus
// hand-written sequences; expected grant order is queued when errors are driven.
module tb_recovery_group_arbiter;

    typedef struct {
        logic [3:0] err;
        logic [3:0] expPending;
        int         expGroup;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   expQ[$];
    vec_t vecs[4];

    recovery_group_arbiter_if #(.NumGroups(4)) bus ();

    recovery_group_arbiter #(
        .NumGroups      (4),
        .TimeoutCycles  (8),
        .CooldownCycles (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Pulse an error pattern for exactly one cycle.
    task automatic applyStimulus(input logic [3:0] err);
        bus.group_error_i = err;
        tick();
        bus.group_error_i = '0;
    endtask

    // Wait (bounded) for the arbiter to raise a request.
    task automatic waitReq(output bit seen);
        for (int i = 0; i < 30; i++) begin
            if (bus.recovery_req_o) break;
            tick();
        end
        seen = bus.recovery_req_o;
        checkOutput("req_seen", 32'(bus.recovery_req_o), 32'd1);
    endtask

    // Serve one request: check the granted group against the scoreboard, ack, run, done.
    task automatic serviceOne(input int busyCycles);
        bit         seen;
        int         exp;
        logic [3:0] oh;
        waitReq(seen);
        if (!seen) return;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_unexpected: got group %0d, expected no grant", bus.recovery_group_o);
            return;
        end
        exp = expQ.pop_front();
        oh  = 4'b0001 << exp;
        checkOutput("grant_group", 32'(bus.recovery_group_o), 32'(exp));
        bus.recovery_ack_i = 1'b1;
        tick();
        bus.recovery_ack_i = 1'b0;
        checkOutput("pending_cleared", 32'(bus.pending_o & oh), 32'd0);
        checkOutput("busy_after_ack", 32'(bus.busy_o), 32'd1);
        checkOutput("req_after_ack", 32'(bus.recovery_req_o), 32'd0);
        repeat (busyCycles) tick();
        checkOutput("clk_en_busy", 32'(bus.group_clk_en_o), 32'(oh));
        bus.recovery_done_i = 1'b1;
        tick();
        bus.recovery_done_i = 1'b0;
        tick();
        tick();
        checkOutput("busy_after_cooldown", 32'(bus.busy_o), 32'd0);
        checkOutput("clk_en_after_cooldown", 32'(bus.group_clk_en_o), 32'hF);
    endtask

    // Hard stop so a hung DUT still yields a summary line.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bit seen;
        checks = 0;
        errors = 0;
        vecs[0] = '{err: 4'b0100, expPending: 4'b0100, expGroup: 2};
        vecs[1] = '{err: 4'b0001, expPending: 4'b0001, expGroup: 0};
        vecs[2] = '{err: 4'b1000, expPending: 4'b1000, expGroup: 3};
        vecs[3] = '{err: 4'b0010, expPending: 4'b0010, expGroup: 1};

        rst_n               = 1'b0;
        bus.group_error_i   = '0;
        bus.recovery_ack_i  = 1'b0;
        bus.recovery_done_i = 1'b0;
        repeat (2) tick();

        // Reset values.
        checkOutput("rst_req", 32'(bus.recovery_req_o), 32'd0);
        checkOutput("rst_group", 32'(bus.recovery_group_o), 32'd0);
        checkOutput("rst_clk_en", 32'(bus.group_clk_en_o), 32'hF);
        checkOutput("rst_pending", 32'(bus.pending_o), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("rst_fatal", 32'(bus.fatal_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Simultaneous errors from rr_ptr=0 are served 0,1,3; pointer then wraps to 0.
        $display("[TB] simultaneous errors");
        applyStimulus(4'b1011);
        checkOutput("multi_pending", 32'(bus.pending_o), 32'hB);
        expQ.push_back(0);
        expQ.push_back(1);
        expQ.push_back(3);
        repeat (3) serviceOne(3);
        applyStimulus(4'b1010);
        expQ.push_back(1);
        expQ.push_back(3);
        repeat (2) serviceOne(3);

        // Single-error table.
        $display("[TB] single-error table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].err);
            checkOutput("single_pending", 32'(bus.pending_o), 32'(vecs[i].expPending));
            expQ.push_back(vecs[i].expGroup);
            serviceOne(3);
        end

        // Error held through its own recovery is masked until cooldown.
        $display("[TB] masking");
        bus.group_error_i = 4'b0010;
        expQ.push_back(1);
        waitReq(seen);
        checkOutput("mask_group", 32'(bus.recovery_group_o), 32'd1);
        void'(expQ.pop_front());
        bus.recovery_ack_i = 1'b1;
        tick();
        bus.recovery_ack_i = 1'b0;
        checkOutput("mask_handshake", 32'(bus.pending_o), 32'd0);
        repeat (3) tick();
        checkOutput("mask_busy", 32'(bus.pending_o), 32'd0);
        bus.recovery_done_i = 1'b1;
        tick();
        bus.recovery_done_i = 1'b0;
        checkOutput("mask_cd_entry", 32'(bus.pending_o), 32'd0);
        tick();
        checkOutput("mask_after_cd", 32'(bus.pending_o), 32'h2);
        bus.group_error_i = '0;
        expQ.push_back(1);
        serviceOne(2);

        // Stray done pulses in IDLE and REQ change nothing.
        $display("[TB] stray done");
        bus.recovery_done_i = 1'b1;
        tick();
        bus.recovery_done_i = 1'b0;
        tick();
        checkOutput("stray_idle_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("stray_idle_req", 32'(bus.recovery_req_o), 32'd0);
        expQ.push_back(0);
        applyStimulus(4'b0001);
        waitReq(seen);
        bus.recovery_done_i = 1'b1;
        tick();
        bus.recovery_done_i = 1'b0;
        tick();
        checkOutput("stray_req_req", 32'(bus.recovery_req_o), 32'd1);
        checkOutput("stray_req_busy", 32'(bus.busy_o), 32'd1);
        serviceOne(2);

        // Watchdog: ack without done; fatal after the 8th BUSY cycle, sticky afterwards.
        $display("[TB] watchdog");
        expQ.push_back(2);
        applyStimulus(4'b0100);
        waitReq(seen);
        checkOutput("wd_group", 32'(bus.recovery_group_o), 32'(expQ.pop_front()));
        bus.recovery_ack_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) bus.recovery_ack_i = 1'b0;
            if (i == 8) checkOutput("wd_not_yet", 32'(bus.fatal_o), 32'd0);
        end
        checkOutput("wd_fatal", 32'(bus.fatal_o), 32'd1);
        checkOutput("wd_idle", 32'(bus.busy_o), 32'd0);
        tick();
        checkOutput("wd_clk_en", 32'(bus.group_clk_en_o), 32'hF);
        expQ.push_back(0);
        applyStimulus(4'b0001);
        serviceOne(2);
        checkOutput("wd_fatal_sticky", 32'(bus.fatal_o), 32'd1);

        // Asynchronous reset in the middle of a recovery.
        $display("[TB] reset mid-busy");
        applyStimulus(4'b1000);
        waitReq(seen);
        bus.recovery_ack_i = 1'b1;
        tick();
        bus.recovery_ack_i = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_req", 32'(bus.recovery_req_o), 32'd0);
        checkOutput("arst_group", 32'(bus.recovery_group_o), 32'd0);
        checkOutput("arst_clk_en", 32'(bus.group_clk_en_o), 32'hF);
        checkOutput("arst_pending", 32'(bus.pending_o), 32'd0);
        checkOutput("arst_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("arst_fatal", 32'(bus.fatal_o), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        checkOutput("post_rst_req", 32'(bus.recovery_req_o), 32'd0);
        checkOutput("post_rst_pending", 32'(bus.pending_o), 32'd0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
